// File: rtl/stack_cpu_controller_if.sv
// Bundle between the stack CPU controller, instruction memory
// and the stack/ALU/data-memory datapath.
interface stack_cpu_controller_if #(
  parameter int PC_W = 8,
  parameter int SP_W = 5
);
  logic [11:0]     instr;
  logic [7:0]      stk_top;
  logic            alu_ovf;
  logic [PC_W-1:0] pc;
  logic            stk_push;
  logic            stk_pop;
  logic [1:0]      din_sel;
  logic [7:0]      imm;
  logic [7:0]      mem_addr;
  logic            mem_we;
  logic            opa_load;
  logic            opb_load;
  logic            alu_op;
  logic            error;
  logic [SP_W-1:0] sp_count;

  modport master (
    input  instr, stk_top, alu_ovf,
    output pc, stk_push, stk_pop, din_sel, imm,
    output mem_addr, mem_we, opa_load, opb_load,
    output alu_op, error, sp_count
  );

  modport slave (
    output instr, stk_top, alu_ovf,
    input  pc, stk_push, stk_pop, din_sel, imm,
    input  mem_addr, mem_we, opa_load, opb_load,
    input  alu_op, error, sp_count
  );
endinterface

// File: rtl/stack_cpu_controller.sv
// Multi-cycle sequencer for the 8-bit stack CPU.
// Macro STACK_CPU_OVF_TRAP_EN traps signed ALU overflow into ERROR.
module stack_cpu_controller #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  stack_cpu_controller_if.master bus
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_PUSHC,
    EXEC_PUSH,
    EXEC_POP,
    EXEC_JUMP,
    EXEC_JZ,
    ALU_B,
    ALU_A,
    ALU_W,
    ERROR
  } state_t;

  state_t          state, state_nx, exec_nx;
  logic [11:0]     ir, ir_nx;
  logic [PC_W-1:0] pc, pc_nx, pc_inc, pc_opd;
  logic [SP_W-1:0] sp, sp_nx, sp_inc, sp_dec;
  logic [3:0]      opcode;
  logic            legal, push_op, pop_op, alu_op2;
  logic            stk_push, stk_pop, mem_we;
  logic            opa_load, opb_load, alu_op;
  logic [1:0]      din_sel;
  logic [7:0]      mem_addr;

  assign opcode  = ir[11:8];
  assign pc_inc  = pc + PC_W'(1);
  assign pc_opd  = PC_W'(ir[7:0]);
  assign sp_inc  = sp + SP_W'(1);
  assign sp_dec  = sp - SP_W'(1);
  assign push_op = (opcode == 4'd0) || (opcode == 4'd1);
  assign pop_op  = (opcode == 4'd2) || (opcode == 4'd4);
  assign alu_op2 = (opcode == 4'd6) || (opcode == 4'd7);
  assign legal   = push_op || pop_op || alu_op2 ||
                   (opcode == 4'd3);

  always_comb begin
    exec_nx = ERROR;
    case (opcode)
      4'd0:    exec_nx = EXEC_PUSHC;
      4'd1:    exec_nx = EXEC_PUSH;
      4'd2:    exec_nx = EXEC_POP;
      4'd3:    exec_nx = EXEC_JUMP;
      4'd4:    exec_nx = EXEC_JZ;
      4'd6,
      4'd7:    exec_nx = ALU_B;
      default: exec_nx = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ir    <= '0;
      pc    <= '0;
      sp    <= '0;
    end else begin
      state <= state_nx;
      ir    <= ir_nx;
      pc    <= pc_nx;
      sp    <= sp_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ir_nx    = ir;
    pc_nx    = pc;
    sp_nx    = sp;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    mem_we   = 1'b0;
    opa_load = 1'b0;
    opb_load = 1'b0;
    alu_op   = 1'b0;
    din_sel  = 2'd0;
    mem_addr = 8'h00;
    unique case (state)
      FETCH: begin
        ir_nx    = bus.instr;
        state_nx = DECODE;
      end
      DECODE: begin
        // Conditions are mutually exclusive by opcode class
        unique case (1'b1)
          !legal:                      state_nx = ERROR;
          push_op && (sp == SP_FULL):  state_nx = ERROR;
          pop_op && (sp == '0):        state_nx = ERROR;
          alu_op2 && (sp < SP_W'(2)):  state_nx = ERROR;
          default:                     state_nx = exec_nx;
        endcase
      end
      EXEC_PUSHC: begin
        stk_push = 1'b1;
        sp_nx    = sp_inc;
        pc_nx    = pc_inc;
        state_nx = FETCH;
      end
      EXEC_PUSH: begin
        mem_addr = ir[7:0];
        stk_push = 1'b1;
        din_sel  = 2'd1;
        sp_nx    = sp_inc;
        pc_nx    = pc_inc;
        state_nx = FETCH;
      end
      EXEC_POP: begin
        mem_addr = ir[7:0];
        mem_we   = 1'b1;
        stk_pop  = 1'b1;
        sp_nx    = sp_dec;
        pc_nx    = pc_inc;
        state_nx = FETCH;
      end
      EXEC_JUMP: begin
        pc_nx    = pc_opd;
        state_nx = FETCH;
      end
      EXEC_JZ: begin
        stk_pop  = 1'b1;
        sp_nx    = sp_dec;
        pc_nx    = (bus.stk_top == 8'h00) ? pc_opd : pc_inc;
        state_nx = FETCH;
      end
      ALU_B: begin
        opb_load = 1'b1;
        stk_pop  = 1'b1;
        sp_nx    = sp_dec;
        state_nx = ALU_A;
      end
      ALU_A: begin
        opa_load = 1'b1;
        stk_pop  = 1'b1;
        sp_nx    = sp_dec;
        state_nx = ALU_W;
      end
      ALU_W: begin
        stk_push = 1'b1;
        din_sel  = 2'd2;
        alu_op   = opcode[0];
        sp_nx    = sp_inc;
`ifdef STACK_CPU_OVF_TRAP_EN
        if (bus.alu_ovf) begin
          state_nx = ERROR;
        end else begin
          pc_nx    = pc_inc;
          state_nx = FETCH;
        end
`else
        pc_nx    = pc_inc;
        state_nx = FETCH;
`endif
      end
      ERROR: begin
        state_nx = ERROR;
      end
      default: begin
        state_nx = FETCH;
      end
    endcase
  end

`ifndef STACK_CPU_OVF_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = bus.alu_ovf;
`endif

  assign bus.pc       = pc;
  assign bus.imm      = ir[7:0];
  assign bus.sp_count = sp;
  assign bus.error    = (state == ERROR);
  assign bus.stk_push = stk_push;
  assign bus.stk_pop  = stk_pop;
  assign bus.din_sel  = din_sel;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_we   = mem_we;
  assign bus.opa_load = opa_load;
  assign bus.opb_load = opb_load;
  assign bus.alu_op   = alu_op;
endmodule

// File: tb/tb_stack_cpu_controller.sv
// Bench for stack_cpu_controller: emulated datapath plus an
// instruction-level reference interpreter, directed and random programs.
module tb_stack_cpu_controller;
  localparam int PC_W  = 8;
  localparam int DEPTH = 16;
  localparam int SP_W  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stack_cpu_controller_if #(.PC_W(PC_W), .SP_W(SP_W)) bus();

  stack_cpu_controller #(
    .PC_W(PC_W),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- emulated datapath / memories ----------------
  logic [11:0] prog [256];
  logic [7:0]  xval;
  logic [7:0]  ram  [256];
  logic [7:0]  stk  [$];
  logic [7:0]  opa, opb, y_last;
  int          y_writes;
  logic        strobe_seen;
  logic [7:0]  alu_res;

  assign bus.instr = prog[bus.pc];
  assign alu_res   = bus.alu_op ? (opa - opb) : (opa + opb);
  assign bus.alu_ovf = bus.alu_op
    ? ((opa[7] != opb[7]) && (alu_res[7] != opa[7]))
    : ((opa[7] == opb[7]) && (alu_res[7] != opa[7]));

  always @(posedge clk or posedge reset) begin
    logic [7:0] t;
    if (reset) begin
      stk.delete();
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      opa = 8'h00;
      opb = 8'h00;
      y_last = 8'h00;
      y_writes = 0;
      strobe_seen = 1'b0;
    end else begin
      t = (stk.size() > 0) ? stk[$] : 8'h00;
      if (bus.stk_push || bus.stk_pop || bus.mem_we ||
          bus.opa_load || bus.opb_load)
        strobe_seen = 1'b1;
      if (bus.opa_load) opa = t;
      if (bus.opb_load) opb = t;
      if (bus.mem_we) begin
        ram[bus.mem_addr] = t;
        if (bus.mem_addr == 8'hFF) begin
          y_last = t;
          y_writes++;
        end
      end
      if (bus.stk_pop && stk.size() > 0) void'(stk.pop_back());
      if (bus.stk_push) begin
        case (bus.din_sel)
          2'd0: stk.push_back(bus.imm);
          2'd1: stk.push_back(bus.mem_addr == 8'hF8 ? xval
                              : ram[bus.mem_addr]);
          2'd2: stk.push_back(alu_res);
          default: stk.push_back(8'hEE);
        endcase
      end
    end
    bus.stk_top = (stk.size() > 0) ? stk[$] : 8'h00;
  end

  // ---------------- instruction-level reference ----------------
  logic [7:0] mstk [$];
  logic [7:0] mram [256];
  logic [7:0] mpc;
  logic       merr;

  task automatic model_reset();
    mstk.delete();
    for (int i = 0; i < 256; i++) mram[i] = 8'h00;
    mpc  = 8'h00;
    merr = 1'b0;
  endtask

  task automatic model_step(output int cyc, output logic ychk,
                            output logic [7:0] yval);
    logic [3:0] op;
    logic [7:0] opd, a, b, r, v;
    logic       ovf;
    op   = prog[mpc][11:8];
    opd  = prog[mpc][7:0];
    ychk = 1'b0;
    yval = 8'h00;
    cyc  = 3;
    if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7}) ||
        (op <= 4'd1 && mstk.size() == DEPTH) ||
        ((op == 4'd2 || op == 4'd4) && mstk.size() == 0) ||
        ((op == 4'd6 || op == 4'd7) && mstk.size() < 2)) begin
      merr = 1'b1;
      cyc  = 2;
      return;
    end
    case (op)
      4'd0: begin mstk.push_back(opd); mpc++; end
      4'd1: begin
        mstk.push_back(opd == 8'hF8 ? xval : mram[opd]);
        mpc++;
      end
      4'd2: begin
        v = mstk.pop_back();
        mram[opd] = v;
        ychk = (opd == 8'hFF);
        yval = v;
        mpc++;
      end
      4'd3: mpc = opd;
      4'd4: begin
        v = mstk.pop_back();
        mpc = (v == 8'h00) ? opd : mpc + 8'd1;
      end
      default: begin
        b = mstk.pop_back();
        a = mstk.pop_back();
        r = (op == 4'd7) ? a - b : a + b;
        ovf = (op == 4'd7)
          ? ($signed({a[7], a}) - $signed({b[7], b}) > 127 ||
             $signed({a[7], a}) - $signed({b[7], b}) < -128)
          : ($signed({a[7], a}) + $signed({b[7], b}) > 127 ||
             $signed({a[7], a}) + $signed({b[7], b}) < -128);
        mstk.push_back(r);
        cyc = 5;
`ifdef STACK_CPU_OVF_TRAP_EN
        if (ovf) merr = 1'b1;
        else mpc++;
`else
        if (ovf || !ovf) mpc++;
`endif
      end
    endcase
  endtask

  function automatic logic [4:0] strobes();
    return {bus.stk_push, bus.stk_pop, bus.mem_we,
            bus.opa_load, bus.opb_load};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc", bus.pc, 0);
    check("rst_sp", bus.sp_count, 0);
    check("rst_err", bus.error, 0);
    check("rst_strb", {strobes(), bus.din_sel, bus.alu_op}, 0);
    reset = 1'b0;
  endtask

  task automatic run_prog(input string name, input int max_instr);
    int         cyc;
    logic       ychk;
    logic [7:0] yval;
    apply_reset();
    for (int i = 0; i < max_instr && !merr; i++) begin
      model_step(cyc, ychk, yval);
      repeat (cyc) @(posedge clk);
      #1;
      check({name, "_pc"}, bus.pc, mpc);
      check({name, "_sp"}, bus.sp_count, mstk.size());
      check({name, "_err"}, bus.error, merr);
      if (ychk) check({name, "_y"}, y_last, yval);
      if (!merr && mstk.size() > 0)
        check({name, "_top"}, bus.stk_top, mstk[$]);
    end
    if (merr) begin
      repeat (3) @(posedge clk);
      #1;
      check({name, "_frz_pc"}, bus.pc, mpc);
      check({name, "_frz_sp"}, bus.sp_count, mstk.size());
      check({name, "_frz_strb"}, strobes(), 0);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 12'h500;
  endtask

  initial begin
    xval = 8'd5;
    clear_prog();
    prog[0]  = 12'h1F8;
    prog[1]  = {4'd0, 8'd23};
    prog[2]  = 12'h600;
    prog[3]  = 12'h2AA;
    prog[4]  = 12'h1AA;
    prog[5]  = 12'h1AA;
    prog[6]  = 12'h600;
    prog[7]  = {4'd0, 8'd12};
    prog[8]  = 12'h700;
    prog[9]  = 12'h2FF;
    prog[10] = {4'd0, 8'd10};
    prog[11] = {4'd3, 8'd10};
    run_prog("demo", 200);
    check("demo_y44", y_last, 8'd44);
    check("demo_ywr", y_writes, 1);
    check("demo_err", bus.error, 1);
    check("demo_sp16", bus.sp_count, 16);
    check("demo_pc10", bus.pc, 10);

    clear_prog();
    prog[0] = 12'h600;
    run_prog("add1st", 4);
    check("add1st_nostrb", strobe_seen, 0);

    clear_prog();
    prog[0] = 12'h900;
    run_prog("op9", 4);
    check("op9_err", bus.error, 1);

    clear_prog();
    prog[0] = 12'h000;
    prog[1] = 12'h407;
    run_prog("jz0", 2);
    check("jz0_pc", bus.pc, 7);
    check("jz0_sp", bus.sp_count, 0);
    prog[0] = 12'h003;
    run_prog("jz3", 2);
    check("jz3_pc", bus.pc, 2);

    clear_prog();
    prog[0] = 12'h005;
    prog[1] = 12'h003;
    prog[2] = 12'h700;
    apply_reset();
    repeat (9) @(posedge clk);
    #1;
    check("midsub_inA", bus.opa_load, 1);
    reset = 1'b1;
    #1;
    check("midsub_pc", bus.pc, 0);
    check("midsub_sp", bus.sp_count, 0);
    check("midsub_strb", strobes(), 0);
    @(posedge clk);
    #1;
    check("midsub_hold", {bus.pc, 3'(bus.sp_count), strobes()}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midsub_fetch", strobes(), 0);
    check("midsub_ir", bus.imm, 8'h05);

    clear_prog();
    prog[0] = 12'h07F;
    prog[1] = 12'h001;
    prog[2] = 12'h600;
    run_prog("ovf", 3);
`ifdef STACK_CPU_OVF_TRAP_EN
    check("ovf_pc", bus.pc, 2);
    check("ovf_err", bus.error, 1);
`else
    check("ovf_pc", bus.pc, 3);
    check("ovf_err", bus.error, 0);
`endif

    for (int p = 0; p < 12; p++) begin
      logic [3:0] op;
      logic [7:0] opd;
      logic [7:0] addrs [6];
      addrs = '{8'hF8, 8'hFF, 8'h10, 8'h11, 8'h12, 8'h13};
      xval = 8'($urandom);
      for (int i = 0; i < 256; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    op = 4'd0;
          2:       op = 4'd1;
          3:       op = 4'd2;
          4:       op = 4'd3;
          5:       op = 4'd4;
          6:       op = 4'd6;
          7:       op = 4'd7;
          8:       op = 4'd0;
          default: op = 4'd6;
        endcase
        if ($urandom_range(0, 39) == 0) op = 4'($urandom_range(8, 15));
        if ($urandom_range(0, 79) == 0) op = 4'd5;
        opd = 8'($urandom);
        if (op == 4'd1 || op == 4'd2) opd = addrs[$urandom_range(0, 5)];
        prog[i] = {op, opd};
      end
      run_prog("rnd", 60);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
